cgol_gen_engine: RTL and testbench
==================================

// Module: cgol_gen_engine
// PURPOSE
//  Generation sequencer and board store for the 8x8 toroidal Life board.
//  - Holds the board in two 8x8 banks: front (displayed) and back (being built).
//  - Feeds decoder_top one row window per cycle and writes its result into the back bank.
//  - Swaps the banks when all 8 rows are done.
//  - Supplies display rows to dispcontrol and accepts host row loads between generations.
// PARAMETERS
//  GEN_W   16  width of generation counter
//  PERIOD  64  run-mode tick interval in cycles (>=1); one tick = one generation request
// PORTS
//  ph1        in   1      sole clock, rising edge
//  reset      in   1      asynchronous, active-low (0 = in reset)
//  load_en    in   1      write load_row into front bank row load_addr
//  load_addr  in   3      row index for load
//  load_row   in   8      row data for load
//  load_ack   out  1      registered; high the cycle after a load was accepted
//  step       in   1      request one generation
//  run        in   1      free-run: request one generation per PERIOD tick
//  row_a      out  8      to decoder_top: front[(r-1) mod 8]
//  row_in     out  8      to decoder_top: front[r]
//  row_b      out  8      to decoder_top: front[(r+1) mod 8]
//  row_next   in   8      from decoder_top: next-gen value of row r (combinational)
//  disp_addr  in   3      display row select
//  disp_row   out  8      front[disp_addr], combinational
//  busy       out  1      high in COMPUTE and SWAP
//  gen_done   out  1      one-cycle pulse after each bank swap
//  gen_count  out  GEN_W  generations completed, wraps 2^GEN_W-1 -> 0
//  all_dead   out  1      combinational: front bank all zero
// BEHAVIOUR
//  Reset (async):
//   - both banks = 0, front select = 0, state IDLE, r = 0
//   - gen_count = 0, gen_done = 0, load_ack = 0, pending = 0, timer = PERIOD-1
//   - A reset during COMPUTE or SWAP aborts the generation; no partial swap occurs.
//  FSM:
//   - IDLE -> COMPUTE when no load this cycle AND (step OR pending). This clears pending and sets r = 0.
//   - COMPUTE, one row per cycle: drive the row_a/row_in/row_b window for r; at the edge, back[r] <= row_next.
//     Then r = 7 -> SWAP; otherwise r++.
//   - SWAP, one cycle: at the edge, flip front select and increment gen_count (wrapping). gen_done <= 1 for the next cycle.
//   - The next state after SWAP is always IDLE.
//  Latency:
//   - step sampled at edge E0 -> COMPUTE cycles 1..8, SWAP cycle 9.
//   - Cycle 10: gen_done=1, busy=0, and disp_row/all_dead reflect the new generation.
//   - busy is high for exactly 9 cycles per generation.
//  Row window:
//   - row_a/row_in/row_b are 0 outside COMPUTE.
//   - Row indices wrap mod 8 (r=0: row_a=front[7]; r=7: row_b=front[0]).
//  Display:
//   - Always reads the front bank, so it is unchanged during COMPUTE (no tearing).
//   - Changes only at the SWAP edge or on a load.
//  Load:
//   - Accepted only in IDLE: front[load_addr] <= load_row and load_ack=1 the next cycle.
//   - Ignored while busy (load_ack stays 0).
//   - Load has priority over start. A step in the same cycle is dropped; pending is kept.
//  Step:
//   - Level-sampled; while held high in IDLE, back-to-back generations run.
//   - Ignored while busy; not queued.
//  Run timer:
//   - Free-running down-counter, PERIOD-1..0, reloads on 0.
//   - When timer==0 and run=1, set pending. Multiple ticks collapse into one pending.
//   - run=0 clears pending.
//  Back bank:
//   - Contents are don't-care outside COMPUTE.
//   - After a swap, the old front becomes the back and is fully overwritten by the next generation.
// TESTING
//  1 Reset: release reset -> disp_row=8'h00 for all disp_addr, gen_count=0, busy=0, all_dead=1, row_a/in/b=0.
//  2 Blinker: load row2=8'b00011100, then pulse step.
//    - At cycle 10: gen_done=1, disp rows 1,2,3=8'b00001000, others 0, gen_count=1.
//    - A second step restores row2=8'b00011100 only.
//  3 Torus corner: load rows 0 and 7 = 8'b10000001, then step -> board unchanged (2x2 block across both wraps), all_dead=0.
//  4 Run mode (PERIOD=16): blinker loaded, run=1 -> gen_done every 16 cycles, gen_count +1 each time, board alternates between phases.
//  5 Busy rules:
//    - step and load_en during cycles 1..9 -> ignored, load_ack=0, board unaffected.
//    - load_en+step in the same IDLE cycle -> load done, no generation started.
//  6 Reset in cycle 4 of COMPUTE -> immediate IDLE, busy=0, board all 0, gen_count=0; GEN_W=4: 16 steps -> gen_count=0.

Source files
------------

// File: rtl/cgol_gen_engine.sv
// Generation sequencer and double-banked board store for an 8x8 toroidal Life board.
// The front bank is the displayed board. The back bank is filled one row per cycle
// from the external row decoder, and the two banks swap once all eight rows are written.
// Ports:
//   ph1, reset                 clock (rising edge) and async active-low reset
//   load_en/load_addr/load_row host row write into the front bank (IDLE only)
//   load_ack                   registered, high the cycle after an accepted load
//   step, run                  single-generation request / periodic free-run enable
//   row_a/row_in/row_b         row window (r-1, r, r+1) sent to the decoder during COMPUTE
//   row_next                   decoder result for row r
//   disp_addr/disp_row         combinational front-bank read port
//   busy, gen_done, gen_count  sequencer status and generation counter
//   all_dead                   combinational, front bank is all zero
module cgol_gen_engine #(
    parameter int unsigned GEN_W  = 16,
    parameter int unsigned PERIOD = 64
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             load_en,
    input  logic [2:0]       load_addr,
    input  logic [7:0]       load_row,
    output logic             load_ack,
    input  logic             step,
    input  logic             run,
    output logic [7:0]       row_a,
    output logic [7:0]       row_in,
    output logic [7:0]       row_b,
    input  logic [7:0]       row_next,
    input  logic [2:0]       disp_addr,
    output logic [7:0]       disp_row,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count,
    output logic             all_dead
);

    localparam int unsigned  TMR_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_SWAP
    } state_e;

    typedef logic [7:0][7:0] bank_t;

    state_e            state_q,     state_d;
    logic [2:0]        r_q,         r_d;
    logic              front_sel_q, front_sel_d;
    bank_t [1:0]       bank_q,      bank_d;
    logic              pending_q,   pending_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic              load_ack_q,  load_ack_d;
    logic              gen_done_q,  gen_done_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;

    logic              tick;
    logic [2:0]        r_prev;
    logic [2:0]        r_next;
    logic              in_compute;

    // State register; reset clears both banks so an aborted generation leaves no residue.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            r_q         <= 3'd0;
            front_sel_q <= 1'b0;
            bank_q      <= '0;
            pending_q   <= 1'b0;
            timer_q     <= TMR_MAX;
            load_ack_q  <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            front_sel_q <= front_sel_d;
            bank_q      <= bank_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            load_ack_q  <= load_ack_d;
            gen_done_q  <= gen_done_d;
            gen_count_q <= gen_count_d;
        end
    end

    // Run timer, pending request and sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        front_sel_d = front_sel_q;
        bank_d      = bank_q;
        load_ack_d  = 1'b0;
        gen_done_d  = 1'b0;
        gen_count_d = gen_count_q;

        tick    = (timer_q == '0);
        timer_d = tick ? TMR_MAX : timer_q - TMR_W'(1);
        // Ticks collapse into a single request; dropping run cancels it.
        pending_d = run ? (pending_q | tick) : 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A load wins over a start; the pending request survives for a later cycle.
                if (load_en) begin
                    bank_d[front_sel_q][load_addr] = load_row;
                    load_ack_d                     = 1'b1;
                end else if (step || pending_q) begin
                    state_d   = ST_COMPUTE;
                    r_d       = 3'd0;
                    pending_d = 1'b0;
                end
            end
            ST_COMPUTE: begin
                bank_d[~front_sel_q][r_q] = row_next;
                if (r_q == 3'd7) begin
                    state_d = ST_SWAP;
                end else begin
                    r_d = r_q + 3'd1;
                end
            end
            ST_SWAP: begin
                front_sel_d = ~front_sel_q;
                gen_count_d = gen_count_q + GEN_W'(1);
                gen_done_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Row window toward the decoder; 3-bit arithmetic gives the toroidal row wrap.
    assign r_prev     = r_q - 3'd1;
    assign r_next     = r_q + 3'd1;
    assign in_compute = (state_q == ST_COMPUTE);

    assign row_a  = in_compute ? bank_q[front_sel_q][r_prev] : 8'h00;
    assign row_in = in_compute ? bank_q[front_sel_q][r_q]    : 8'h00;
    assign row_b  = in_compute ? bank_q[front_sel_q][r_next] : 8'h00;

    // Display always reads the front bank, so a generation in progress is never visible.
    assign disp_row = bank_q[front_sel_q][disp_addr];
    assign all_dead = (bank_q[front_sel_q] == '0);

    assign busy      = (state_q != ST_IDLE);
    assign load_ack  = load_ack_q;
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_cgol_gen_engine.sv
// Self-checking bench for cgol_gen_engine: a Life row decoder model closes the loop,
// a whole-board reference model predicts each generation, and a monitor thread pops
// expectations from a scoreboard queue on every gen_done or snapshot request.
`timescale 1ns/1ps
module tb_cgol_gen_engine;

    localparam int unsigned GEN_W  = 4;
    localparam int unsigned PERIOD = 16;

    typedef logic [7:0][7:0] board_t;

    typedef struct {
        bit               is_snap;
        board_t           board;
        logic [GEN_W-1:0] count;
        int               exp_cyc;
        bit               chk_int;
    } exp_t;

    logic             ph1;
    logic             reset;
    logic             load_en;
    logic [2:0]       load_addr;
    logic [7:0]       load_row;
    logic             load_ack;
    logic             step;
    logic             run;
    logic [7:0]       row_a;
    logic [7:0]       row_in;
    logic [7:0]       row_b;
    logic [7:0]       row_next;
    logic [2:0]       disp_addr;
    logic [7:0]       disp_row;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    logic             all_dead;

    cgol_gen_engine #(
        .GEN_W  (GEN_W),
        .PERIOD (PERIOD)
    ) dut (
        .ph1       (ph1),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_row  (load_row),
        .load_ack  (load_ack),
        .step      (step),
        .run       (run),
        .row_a     (row_a),
        .row_in    (row_in),
        .row_b     (row_b),
        .row_next  (row_next),
        .disp_addr (disp_addr),
        .disp_row  (disp_row),
        .busy      (busy),
        .gen_done  (gen_done),
        .gen_count (gen_count),
        .all_dead  (all_dead)
    );

    initial ph1 = 1'b0;
    always #10 ph1 = ~ph1;

    int cyc = 0;
    always @(posedge ph1) cyc <= cyc + 1;

    // Life rule applied to one row given its upper and lower neighbours (columns wrap).
    function automatic logic [7:0] dec_row(input logic [7:0] a, input logic [7:0] m,
                                           input logic [7:0] b);
        logic [7:0] o;
        o = 8'h00;
        for (int c = 0; c < 8; c++) begin
            int l;
            int rr;
            int n;
            l  = (c + 7) % 8;
            rr = (c + 1) % 8;
            n  = int'(a[3'(l)]) + int'(a[3'(c)]) + int'(a[3'(rr)]) +
                 int'(m[3'(l)]) + int'(m[3'(rr)]) +
                 int'(b[3'(l)]) + int'(b[3'(c)]) + int'(b[3'(rr)]);
            o[3'(c)] = (n == 3) || (m[3'(c)] && (n == 2));
        end
        return o;
    endfunction

    always_comb row_next = dec_row(row_a, row_in, row_b);

    // Whole-board reference: count the eight toroidal neighbours of every cell.
    function automatic board_t life(input board_t cur);
        board_t nxt;
        nxt = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            n += int'(cur[3'((r + dr + 8) % 8)][3'((c + dc + 8) % 8)]);
                        end
                    end
                end
                nxt[3'(r)][3'(c)] = (n == 3) || (cur[3'(r)][3'(c)] && (n == 2));
            end
        end
        return nxt;
    endfunction

    int               total = 0;
    int               bad   = 0;
    exp_t             q[$];
    board_t           exp_front;
    logic [GEN_W-1:0] exp_cnt;
    bit               mon_active;
    int               last_done;
    int               busy_run;
    int               last_run;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic compare_board(input exp_t e);
        for (int a = 0; a < 8; a++) begin
            disp_addr = 3'(a);
            #1;
            chk($sformatf("disp_row[%0d]", a), 64'(disp_row), 64'(e.board[3'(a)]));
        end
        chk("gen_count", 64'(gen_count), 64'(e.count));
        chk("all_dead", 64'(all_dead), 64'(e.board == '0));
    endtask

    task automatic push_snap();
        exp_t e;
        e.is_snap = 1'b1;
        e.board   = exp_front;
        e.count   = exp_cnt;
        e.exp_cyc = -1;
        e.chk_int = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_gen(input board_t b, input int ec, input bit ci);
        exp_t e;
        exp_cnt   = exp_cnt + GEN_W'(1);
        exp_front = b;
        e.is_snap = 1'b0;
        e.board   = b;
        e.count   = exp_cnt;
        e.exp_cyc = ec;
        e.chk_int = ci;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || mon_active || busy) && n < budget) begin
            @(posedge ph1);
            #1;
            n++;
        end
        chk("drain_pending_entries", 64'(q.size()), 64'(0));
        q.delete();
    endtask

    task automatic do_load(input logic [2:0] addr, input logic [7:0] val);
        load_en   = 1'b1;
        load_addr = addr;
        load_row  = val;
        @(posedge ph1);
        #1;
        load_en = 1'b0;
        chk("load_ack", 64'(load_ack), 64'(1'b1));
        exp_front[addr] = val;
    endtask

    task automatic set_board(input board_t b);
        for (int r = 0; r < 8; r++) do_load(3'(r), b[3'(r)]);
        push_snap();
        wait_drain(20);
    endtask

    task automatic do_step(input board_t expb);
        step = 1'b1;
        @(posedge ph1);
        #1;
        step = 1'b0;
        push_gen(expb, cyc + 9, 1'b0);
        wait_drain(40);
    endtask

    // Step plus load/step noise on every busy cycle; none of it may take effect.
    task automatic do_step_noisy();
        step = 1'b1;
        @(posedge ph1);
        #1;
        push_gen(life(exp_front), cyc + 9, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            load_en   = 1'b1;
            load_addr = 3'($urandom_range(0, 7));
            load_row  = 8'($urandom);
            step      = 1'b1;
            @(posedge ph1);
            #1;
            chk("busy_load_ack", 64'(load_ack), 64'(1'b0));
        end
        load_en = 1'b0;
        step    = 1'b0;
        wait_drain(40);
    endtask

    // Step held high: a new generation starts every 10 cycles.
    task automatic do_held(input int k);
        step = 1'b1;
        for (int i = 0; i < k; i++) begin
            repeat ((i == 0) ? 1 : 10) @(posedge ph1);
            #1;
            push_gen(life(exp_front), cyc + 9, 1'b0);
        end
        step = 1'b0;
        wait_drain(40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at cyc %0d, want finished", cyc);
        $fatal(1);
    end

    initial begin
        board_t b;
        exp_t   e;

        reset      = 1'b0;
        load_en    = 1'b0;
        load_addr  = 3'd0;
        load_row   = 8'h00;
        step       = 1'b0;
        run        = 1'b0;
        disp_addr  = 3'd0;
        exp_front  = '0;
        exp_cnt    = '0;
        mon_active = 1'b0;
        last_done  = 0;
        busy_run   = 0;
        last_run   = 0;

        fork
            forever begin
                @(negedge ph1);
                if (reset) begin
                    if (busy) begin
                        busy_run++;
                    end else begin
                        last_run = busy_run;
                        busy_run = 0;
                        chk("idle_window", 64'({row_a, row_in, row_b}), 64'(0));
                    end
                    if (gen_done) begin
                        mon_active = 1'b1;
                        if (q.size() == 0 || q[0].is_snap) begin
                            chk("unexpected_gen_done", 64'(gen_done), 64'(1'b0));
                        end else begin
                            e = q.pop_front();
                            chk("busy_cycles", 64'(last_run), 64'(9));
                            if (e.exp_cyc >= 0) chk("done_latency", 64'(cyc), 64'(e.exp_cyc));
                            if (e.chk_int) chk("run_interval", 64'(cyc - last_done), 64'(PERIOD));
                            compare_board(e);
                        end
                        last_done  = cyc;
                        mon_active = 1'b0;
                    end else if (q.size() != 0 && q[0].is_snap && !busy) begin
                        mon_active = 1'b1;
                        e = q.pop_front();
                        compare_board(e);
                        mon_active = 1'b0;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge ph1);
        #1;
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_gen_count", 64'(gen_count), 64'(0));
        chk("rst_all_dead", 64'(all_dead), 64'(1'b1));
        chk("rst_window", 64'({row_a, row_in, row_b}), 64'(0));
        chk("rst_load_ack", 64'(load_ack), 64'(1'b0));
        chk("rst_gen_done", 64'(gen_done), 64'(1'b0));
        reset = 1'b1;
        push_snap();
        wait_drain(20);

        // Blinker, two phases
        do_load(3'd2, 8'b0001_1100);
        push_snap();
        wait_drain(20);
        b    = '0;
        b[1] = 8'b0000_1000;
        b[2] = 8'b0000_1000;
        b[3] = 8'b0000_1000;
        do_step(b);
        b    = '0;
        b[2] = 8'b0001_1100;
        do_step(b);

        // 2x2 block split across both wrap seams
        b    = '0;
        b[0] = 8'b1000_0001;
        b[7] = 8'b1000_0001;
        set_board(b);
        do_step(b);

        // Busy rules: noise while busy, then load+step together in IDLE
        do_step_noisy();
        load_en   = 1'b1;
        step      = 1'b1;
        load_addr = 3'd5;
        load_row  = 8'b0111_0000;
        @(posedge ph1);
        #1;
        load_en = 1'b0;
        step    = 1'b0;
        chk("load_step_ack", 64'(load_ack), 64'(1'b1));
        exp_front[5] = 8'b0111_0000;
        repeat (12) begin
            @(posedge ph1);
            #1;
            chk("load_step_no_gen", 64'(busy), 64'(1'b0));
        end
        push_snap();
        wait_drain(20);

        // Run mode: blinker toggles once per timer period
        b    = '0;
        b[4] = 8'b0011_1000;
        set_board(b);
        run = 1'b1;
        for (int i = 0; i < 4; i++) push_gen(life(exp_front), -1, i > 0);
        wait_drain(140);
        run = 1'b0;
        repeat (40) @(posedge ph1);
        #1;

        // Reset in the fourth COMPUTE cycle aborts the generation
        step = 1'b1;
        @(posedge ph1);
        #1;
        step = 1'b0;
        repeat (3) @(posedge ph1);
        #1;
        chk("pre_abort_busy", 64'(busy), 64'(1'b1));
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_gen_count", 64'(gen_count), 64'(0));
        chk("abort_all_dead", 64'(all_dead), 64'(1'b1));
        chk("abort_window", 64'({row_a, row_in, row_b}), 64'(0));
        #1;
        reset     = 1'b1;
        exp_front = '0;
        exp_cnt   = '0;
        repeat (15) @(posedge ph1);
        #1;
        push_snap();
        wait_drain(20);

        // Counter wrap: 16 held-step generations bring a 4-bit count back to 0
        b    = '0;
        b[6] = 8'b1110_0000;
        set_board(b);
        do_held(16);
        push_snap();
        wait_drain(20);
        chk("wrap_model_count", 64'(gen_count), 64'(0));

        // Randomised mix
        for (int r = 0; r < 8; r++) b[3'(r)] = 8'($urandom) & 8'($urandom);
        set_board(b);
        repeat (14) begin
            case ($urandom_range(0, 3))
                0: begin
                    repeat ($urandom_range(1, 4)) do_load(3'($urandom_range(0, 7)), 8'($urandom));
                    push_snap();
                    wait_drain(20);
                end
                1: do_step(life(exp_front));
                2: do_step_noisy();
                default: do_held(int'($urandom_range(2, 3)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
